// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package writeback_arbiter_pkg;
  localparam int WIDTH             = 16;
  localparam int LOG_NUM_REGISTERS = 3;
  localparam int NUM_REGISTERS     = 8;

  // Which stream owns the register-file write port this cycle
  typedef enum logic [1:0] {SRC_NONE, SRC_MEM, SRC_BUF, SRC_ALU} wb_src_t;

  // One register-file write: destination and data
  typedef struct packed {
    logic [LOG_NUM_REGISTERS-1:0] addr;
    logic [WIDTH-1:0]             data;
  } wb_req_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of result streams, issue/scoreboard and register-file write port.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic                         alu_valid;
  logic [LOG_NUM_REGISTERS-1:0] alu_addr;
  logic [WIDTH-1:0]             alu_data;
  logic                         alu_ready;
  logic                         mem_valid;
  logic [LOG_NUM_REGISTERS-1:0] mem_addr;
  logic [WIDTH-1:0]             mem_data;
  logic                         issue_valid;
  logic [LOG_NUM_REGISTERS-1:0] issue_addr;
  logic [NUM_REGISTERS-1:0]     pending;
  logic                         protocol_err;
  logic                         writeEnable;
  logic [LOG_NUM_REGISTERS-1:0] writeAddr;
  logic [WIDTH-1:0]             d;

  // Pipeline side: produces results and issues destinations
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr,
    input  alu_ready, pending, protocol_err, writeEnable, writeAddr, d
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr,
    output alu_ready, pending, protocol_err, writeEnable, writeAddr, d
  );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small in-order skid buffer holding ALU results that lost arbitration.
module wb_skid_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  wb_req_t din_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  wb_req_t [BUF_DEPTH-1:0] mem_q;
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]           count_q;
  logic                    do_push, do_pop;

  assign full_o  = (count_q == CW'(BUF_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers (wrap naturally, depth is a power of 2) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges mem and ALU results onto the register-file write port and keeps
// the per-register pending scoreboard used by decode for hazard stalls.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  writeback_arbiter_if.slave wb
);
  wb_src_t                  sel;
  wb_req_t                  alu_req, mem_req, head, wr_d;
  logic                     full, empty, push, pop;
  logic                     we_q;
  wb_req_t                  wr_q;
  logic [NUM_REGISTERS-1:0] pending_q, pending_d;
  logic                     perr_q, perr_d, clr_hit;

  assign alu_req = {wb.alu_addr, wb.alu_data};
  assign mem_req = {wb.mem_addr, wb.mem_data};

  // No pass-through while full, even if the head pops this cycle
  assign wb.alu_ready = !full;

  // Fixed priority: loads never stall, buffered ALU results before new ones
  always_comb begin
    sel = SRC_NONE;
    if (wb.mem_valid)                sel = SRC_MEM;
    else if (!empty)                 sel = SRC_BUF;
    else if (wb.alu_valid)           sel = SRC_ALU;
  end

  // Any accepted ALU result not written directly goes into the buffer
  assign push = wb.alu_valid && !full && (sel != SRC_ALU);
  assign pop  = (sel == SRC_BUF);

  // Data for the selected source
  always_comb begin
    wr_d = '0;
    case (sel)
      SRC_MEM: wr_d = mem_req;
      SRC_BUF: wr_d = head;
      SRC_ALU: wr_d = alu_req;
      default: wr_d = '0;
    endcase
  end

  wb_skid_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (alu_req),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Registered write port; addr/data hold when nothing is selected
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q <= 1'b0;
      wr_q <= '0;
    end else begin
      we_q <= (sel != SRC_NONE);
      if (sel != SRC_NONE) wr_q <= wr_d;
    end
  end

  // A register being written on this edge is no longer outstanding, so
  // re-issuing it on the same edge is legal
  assign clr_hit = we_q && (wr_q.addr == wb.issue_addr);

  // Scoreboard next state: clear on write, set on issue (set wins)
  always_comb begin
    pending_d = pending_q;
    if (we_q)           pending_d[wr_q.addr]     = 1'b0;
    if (wb.issue_valid) pending_d[wb.issue_addr] = 1'b1;
    perr_d = perr_q | (wb.issue_valid && pending_q[wb.issue_addr] && !clr_hit);
  end

  // Scoreboard and sticky error state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      perr_q    <= perr_d;
    end
  end

  assign wb.writeEnable  = we_q;
  assign wb.writeAddr    = wr_q.addr;
  assign wb.d            = wr_q.data;
  assign wb.pending      = pending_q;
  assign wb.protocol_err = perr_q;
endmodule
